// File: rtl/udma_uart_rx_pkg.sv
// udma_uart_rx_pkg: shared types and helpers for the UART RX buffer.
package udma_uart_rx_pkg;

    typedef enum logic [1:0] {TO_IDLE, TO_COUNT, TO_FIRED} t_to_state_e;

    localparam int DATA_WIDTH_MIN = 5;
    localparam int DATA_WIDTH_MAX = 9;

    function automatic int f_lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/udma_uart_rx_sync_fifo.sv
// udma_uart_rx_sync_fifo: single-clock FIFO with level count; a pop frees the slot for a same-cycle push.
module udma_uart_rx_sync_fifo
    import udma_uart_rx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int LW = f_lvl_w(DEPTH)
) (
    input  logic             sys_clk_i,
    input  logic             rstn_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             push_ok_o,
    output logic             pop_ok_o,
    output logic [LW-1:0]    level_o,
    output logic [LW-1:0]    level_next_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [LW-2:0]    wptr_q, rptr_q;
    logic [LW-1:0]    level_q;

    assign empty_o      = level_q == '0;
    assign full_o       = level_q == LW'(DEPTH);
    assign pop_ok_o     = pop_i && !empty_o;
    assign push_ok_o    = push_i && (!full_o || pop_ok_o);
    assign level_o      = level_q;
    assign level_next_o = clr_i ? '0 : level_q + LW'(push_ok_o) - LW'(pop_ok_o);
    assign rdata_o      = mem_q[rptr_q];

    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else if (clr_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_q + (LW-1)'(push_ok_o);
            rptr_q  <= rptr_q + (LW-1)'(pop_ok_o);
            level_q <= level_next_o;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (push_ok_o && !clr_i)
            mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/udma_uart_rx_buffer.sv
// udma_uart_rx_buffer: UART RX buffer with DMA/polling drain, watermark and idle-timeout events.
// Define UDMA_UART_RX_PERR_TAG_EN to store the parity error flag with each character.
module udma_uart_rx_buffer
    import udma_uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int TO_WIDTH   = 16,
    localparam int LW = f_lvl_w(DEPTH)
) (
    input  logic                  sys_clk_i,
    input  logic                  rstn_i,
    input  logic                  clr_i,
    input  logic                  cfg_dma_en_i,
    input  logic [LW-1:0]         cfg_watermark_i,
    input  logic [TO_WIDTH-1:0]   cfg_timeout_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_perr_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [31:0]           dma_data_o,
    output logic                  dma_valid_o,
    input  logic                  dma_ready_i,
    input  logic                  poll_rd_i,
    output logic [DATA_WIDTH-1:0] poll_data_o,
    output logic                  poll_perr_o,
    output logic                  poll_valid_o,
    output logic [LW-1:0]         level_o,
    output logic                  overflow_o,
    output logic                  wm_event_o,
    output logic                  timeout_event_o
);

`ifdef UDMA_UART_RX_PERR_TAG_EN
    localparam int EW = DATA_WIDTH + 1;
    logic [EW-1:0] wdata, head;
    assign wdata = {in_perr_i, in_data_i};
    logic head_perr;
    assign head_perr = head[DATA_WIDTH];
`else
    localparam int EW = DATA_WIDTH;
    logic [EW-1:0] wdata, head;
    logic unused_perr;
    assign wdata       = in_data_i;
    assign unused_perr = in_perr_i;
    logic head_perr;
    assign head_perr = 1'b0;
`endif

    logic               empty, full, push_ok, pop_ok, pop;
    logic [LW-1:0]      level_next;
    logic               overflow_q, overflow_d, wm_q, wm_d, to_evt_q, to_evt_d;
    t_to_state_e        to_state_q, to_state_d;
    logic [TO_WIDTH-1:0] to_cnt_q, to_cnt_d;
    logic [TO_WIDTH:0]  cnt_inc;

    udma_uart_rx_sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .sys_clk_i    (sys_clk_i),
        .rstn_i       (rstn_i),
        .clr_i        (clr_i),
        .push_i       (in_valid_i),
        .pop_i        (pop),
        .wdata_i      (wdata),
        .rdata_o      (head),
        .empty_o      (empty),
        .full_o       (full),
        .push_ok_o    (push_ok),
        .pop_ok_o     (pop_ok),
        .level_o      (level_o),
        .level_next_o (level_next)
    );

    assign in_ready_o      = 1'b1;
    assign dma_valid_o     = !empty && cfg_dma_en_i;
    assign poll_valid_o    = !empty && !cfg_dma_en_i;
    assign pop             = (dma_valid_o && dma_ready_i) || (poll_valid_o && poll_rd_i);
    assign dma_data_o      = dma_valid_o ? {head_perr, {(31-DATA_WIDTH){1'b0}}, head[DATA_WIDTH-1:0]} : '0;
    assign poll_data_o     = poll_valid_o ? head[DATA_WIDTH-1:0] : '0;
    assign poll_perr_o     = poll_valid_o && head_perr;
    assign overflow_o      = overflow_q;
    assign wm_event_o      = wm_q;
    assign timeout_event_o = to_evt_q;

    assign overflow_d = !clr_i && (overflow_q || (in_valid_i && full && !pop_ok));
    assign wm_d       = !clr_i && |cfg_watermark_i && level_o < cfg_watermark_i && level_next >= cfg_watermark_i;
    assign cnt_inc    = {1'b0, to_cnt_q} + (TO_WIDTH+1)'(1);

    // Any accepted push or pop restarts the idle count; a full FIFO with dropped input stays idle.
    always_comb begin
        to_state_d = to_state_q;
        to_cnt_d   = to_cnt_q;
        to_evt_d   = 1'b0;
        if (clr_i || level_next == '0) begin
            to_state_d = TO_IDLE;
            to_cnt_d   = '0;
        end else if (push_ok || pop_ok) begin
            to_state_d = TO_COUNT;
            to_cnt_d   = '0;
        end else if (to_state_q == TO_COUNT && |cfg_timeout_i) begin
            to_state_d = cnt_inc >= {1'b0, cfg_timeout_i} ? TO_FIRED : TO_COUNT;
            to_evt_d   = cnt_inc >= {1'b0, cfg_timeout_i};
            to_cnt_d   = cnt_inc[TO_WIDTH-1:0];
        end
    end

    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            overflow_q <= 1'b0;
            wm_q       <= 1'b0;
            to_evt_q   <= 1'b0;
            to_state_q <= TO_IDLE;
            to_cnt_q   <= '0;
        end else begin
            overflow_q <= overflow_d;
            wm_q       <= wm_d;
            to_evt_q   <= to_evt_d;
            to_state_q <= to_state_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

endmodule
